uart_tx_fifo_param: RTL and testbench



---
 rtl/uart_tx_fifo_param.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// UART transmitter with an integrated baud divider, configurable frame format
// (data bits, parity, stop bits) and a small transmit FIFO for back-to-back frames.
module uart_tx_fifo_param #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          baud_tick
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);

  if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_tx_fifo_param: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Transmit FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 have_data;
  logic [DATA_BITS-1:0] head;

  // Frame FSM state
  state_t               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_d;
  logic                 busy_d;
  logic                 tick_c;

  assign tx_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push      = tx_valid & tx_ready;
  assign have_data = (fifo_count != '0);
  assign head      = mem[rd_ptr];
  assign tick_c    = (state_q != S_IDLE) && (baud_q == BAUD_W'(BAUD_DIV - 1));
  assign baud_tick = tick_c;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // FIFO pointers and occupancy; pop is only raised while non-empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FSM state and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tx_serial <= line_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    line_d  = 1'b1;
    busy_d  = 1'b0;

    if (state_q != S_IDLE) baud_d = tick_c ? '0 : baud_q + BAUD_W'(1);

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (have_data) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = frame_parity(head);
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick_c) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick_c) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_c) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d = '0;
            // Chain straight into the next frame when more data is queued
            if (have_data) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = frame_parity(head);
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered so tx_serial stays registered
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: three frame formats, FIFO burst,
// simultaneous push/pop and reset abort, checked with immediate assertions.
module tb_uart_tx_fifo_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       v0, v1, v2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic       rdy0, rdy1, rdy2;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic [2:0] cnt0, cnt1, cnt2;
  logic       tick0, tick1, tick2;

  // 8N1, BAUD_DIV=4
  uart_tx_fifo_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0), .tx_ready(rdy0),
    .tx_serial(tx0), .busy(busy0), .fifo_count(cnt0), .baud_tick(tick0));

  // 8E1, BAUD_DIV=4
  uart_tx_fifo_param #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1), .tx_ready(rdy1),
    .tx_serial(tx1), .busy(busy1), .fifo_count(cnt1), .baud_tick(tick1));

  // 7O2, BAUD_DIV=3
  uart_tx_fifo_param #(.BAUD_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
    .clk(clk), .rst(rst), .tx_valid(v2), .tx_data(d2), .tx_ready(rdy2),
    .tx_serial(tx2), .busy(busy2), .fifo_count(cnt2), .baud_tick(tick2));

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic       line_s [300];
  logic       busy_s [300];
  logic       tick_s [300];
  logic [2:0] cnt_s  [300];

  logic [7:0] rx_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [8:0] data);
    case (sel)
      0:       begin v0 = 1'b1; d0 = data[7:0]; end
      1:       begin v1 = 1'b1; d1 = data[7:0]; end
      default: begin v2 = 1'b1; d2 = data[6:0]; end
    endcase
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (sel)
        0:       begin line_s[i] = tx0; busy_s[i] = busy0; tick_s[i] = tick0; cnt_s[i] = cnt0; end
        1:       begin line_s[i] = tx1; busy_s[i] = busy1; tick_s[i] = tick1; cnt_s[i] = cnt1; end
        default: begin line_s[i] = tx2; busy_s[i] = busy2; tick_s[i] = tick2; cnt_s[i] = cnt2; end
      endcase
    end
  endtask

  function automatic int count_busy(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (busy_s[i] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_ticks(input int n);
    int c = 0;
    for (int i = 0; i < n; i++) if (tick_s[i] === 1'b1) c++;
    return c;
  endfunction

  // Mid-bit samples packed LSB-first; glitches counts samples differing within a bit
  task automatic decode(input int start, input int nbits, input int bd,
                        output logic [15:0] vec, output int glitches);
    vec = '0;
    glitches = 0;
    for (int b = 0; b < nbits; b++) begin
      vec[b] = line_s[start + bd*b + bd/2];
      for (int k = 0; k < bd; k++)
        if (line_s[start + bd*b + k] !== vec[b]) glitches++;
    end
  endtask

  task automatic check_rx(input string tag, input int n, input logic [7:0] first, input logic [7:0] step);
    logic [7:0] got;
    chk({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < int'(rx_q.size())) ? rx_q[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(8'(first + 8'(i) * step)));
    end
  endtask

  // Passive 8N1 receiver on u_8n1 (BAUD_DIV=4), sampling mid-bit
  initial begin : rx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx0 === 1'b0) begin
        repeat (6) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx0;
          if (i < 7) repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        if (tx0 === 1'b1) rx_q.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] vec;
    int          gl;
    int          waited;
    int          lows;

    rst = 1'b1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    d0 = '0;   d1 = '0;   d2 = '0;

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_tx",    32'(tx0),   32'd1);
    chk("rst_busy",  32'(busy0), 32'd0);
    chk("rst_tick",  32'(tick0), 32'd0);
    chk("rst_count", 32'(cnt0),  32'd0);
    chk("rst_ready", 32'(rdy0),  32'd1);
    chk("rst_tx_7o2", 32'(tx2),  32'd1);
    chk("rst_ready_8e1", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // 8N1, 0x55: one-cycle pop latency, 40-clock frame
    push(0, 9'h055);
    capture(0, 46);
    chk("8n1_pre_line",  32'(line_s[0]), 32'd1);
    chk("8n1_pre_count", 32'(cnt_s[0]),  32'd1);
    chk("8n1_start_fall", 32'(line_s[1]), 32'd0);
    decode(1, 10, 4, vec, gl);
    chk("8n1_frame", 32'(vec), 32'h2AA);
    chk("8n1_glitch", 32'(gl), 32'd0);
    chk("8n1_busy_clks", 32'(count_busy(46)), 32'd40);
    chk("8n1_ticks", 32'(count_ticks(46)), 32'd10);
    chk("8n1_idle_line", 32'(line_s[41]), 32'd1);
    chk("8n1_idle_busy", 32'(busy_s[41]), 32'd0);
    check_rx("8n1_rx", 1, 8'h55, 8'h00);
    rx_q.delete();

    // 8E1, 0x03 then 0x07 back-to-back
    push(1, 9'h003);
    push(1, 9'h007);
    capture(1, 92);
    chk("8e1_count_pushpop", 32'(cnt_s[0]), 32'd1);
    decode(0, 11, 4, vec, gl);
    chk("8e1_frame1", 32'(vec), 32'h406);
    chk("8e1_glitch1", 32'(gl), 32'd0);
    decode(44, 11, 4, vec, gl);
    chk("8e1_frame2", 32'(vec), 32'h60E);
    chk("8e1_glitch2", 32'(gl), 32'd0);
    chk("8e1_last_stop", 32'(line_s[43]), 32'd1);
    chk("8e1_no_gap", 32'(line_s[44]), 32'd0);
    chk("8e1_busy_clks", 32'(count_busy(92)), 32'd88);
    chk("8e1_ticks", 32'(count_ticks(92)), 32'd22);
    chk("8e1_idle_busy", 32'(busy_s[88]), 32'd0);

    // 7O2, BAUD_DIV=3, 0x7F
    push(2, 9'h07F);
    capture(2, 36);
    chk("7o2_pre_line", 32'(line_s[0]), 32'd1);
    decode(1, 11, 3, vec, gl);
    chk("7o2_frame", 32'(vec), 32'h6FE);
    chk("7o2_glitch", 32'(gl), 32'd0);
    chk("7o2_busy_clks", 32'(count_busy(36)), 32'd33);
    chk("7o2_ticks", 32'(count_ticks(36)), 32'd11);
    chk("7o2_idle_line", 32'(line_s[34]), 32'd1);
    chk("7o2_idle_busy", 32'(busy_s[34]), 32'd0);

    // FIFO burst: six bytes with tx_valid held, stall on full
    v0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d0 = 8'(8'h11 + 8'(i));
      @(posedge clk); #1;
    end
    d0 = 8'h16;
    @(negedge clk);
    chk("burst_full_count", 32'(cnt0), 32'd4);
    chk("burst_full_ready", 32'(rdy0), 32'd0);
    waited = 0;
    while (rdy0 !== 1'b1 && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("burst_stall_clks", 32'(waited), 32'd37);
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    chk("burst_refill_count", 32'(cnt0), 32'd4);
    repeat (280) @(negedge clk);
    check_rx("burst_rx", 6, 8'h11, 8'h01);
    rx_q.delete();

    // Simultaneous push and pop at fifo_count=2
    @(posedge clk); #1;
    push(0, 9'h031);
    push(0, 9'h032);
    push(0, 9'h033);
    @(negedge clk);
    chk("pp_count_before", 32'(cnt0), 32'd2);
    repeat (38) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pp_count_prepop", 32'(cnt0), 32'd2);
    v0 = 1'b1; d0 = 8'h34;
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    chk("pp_count_same", 32'(cnt0), 32'd2);
    chk("pp_next_start", 32'(tx0), 32'd0);
    chk("pp_busy", 32'(busy0), 32'd1);
    repeat (200) @(negedge clk);
    check_rx("pp_rx", 4, 8'h31, 8'h01);
    rx_q.delete();

    // Reset mid-DATA of a 0x00 frame with another byte queued
    @(posedge clk); #1;
    push(0, 9'h000);
    push(0, 9'h022);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_mid_busy", 32'(busy0), 32'd1);
    chk("abort_mid_line", 32'(tx0), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_line", 32'(tx0), 32'd1);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_count", 32'(cnt0), 32'd0);
    chk("abort_tick", 32'(tick0), 32'd0);
    chk("abort_ready", 32'(rdy0), 32'd1);
    repeat (50) @(negedge clk);
    rx_q.delete();
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) lows++;
    end
    chk("abort_quiet", 32'(lows), 32'd0);
    chk("abort_rx_empty", 32'(rx_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
